// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic ops, full-width
// multiply, and a WIDTH-cycle restoring divider returning quotient and remainder.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry,
    output logic             zero,
    output logic             dz
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             carry_q;
    logic             zero_q;
    logic             dz_q;

    // Divider state: dvd_q starts as the dividend and fills with quotient bits.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   hi_d;
    logic               carry_d;
    logic               dz_d;
    logic               zero_d;
    logic               is_div;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_sub;
    logic             ge;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        lo_d    = sum[WIDTH-1:0];
        hi_d    = '0;
        carry_d = sum[WIDTH];
        dz_d    = 1'b0;
        case (op)
            4'b0001: begin
                lo_d    = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];
            end
            4'b0010: begin
                lo_d    = prod[WIDTH-1:0];
                hi_d    = prod[2*WIDTH-1:WIDTH];
                carry_d = 1'b0;
            end
            4'b0011: begin
                lo_d    = '1;
                hi_d    = a;
                carry_d = 1'b0;
                dz_d    = 1'b1;
            end
            4'b0100: begin
                lo_d    = {a[WIDTH-2:0], 1'b0};
                carry_d = a[WIDTH-1];
            end
            4'b0101: begin
                lo_d    = {1'b0, a[WIDTH-1:1]};
                carry_d = a[0];
            end
            4'b1000: begin lo_d = a & b;    carry_d = 1'b0; end
            4'b1001: begin lo_d = a | b;    carry_d = 1'b0; end
            4'b1010: begin lo_d = a ^ b;    carry_d = 1'b0; end
            4'b1011: begin lo_d = ~(a | b); carry_d = 1'b0; end
            4'b1100: begin lo_d = ~(a & b); carry_d = 1'b0; end
            4'b1101: begin lo_d = ~(a ^ b); carry_d = 1'b0; end
            default: ;
        endcase
        zero_d = ({hi_d, lo_d} == '0);
        is_div = (op == 4'b0011) && (b != '0);
    end

    // One restoring step; the remainder stays below the divisor, so the
    // subtraction fits in WIDTH bits.
    always_comb begin
        trial   = {rem_q, dvd_q[WIDTH-1]};
        ge      = (trial >= {1'b0, b_q});
        rem_sub = trial[WIDTH-1:0] - b_q;
        rem_d   = ge ? rem_sub : trial[WIDTH-1:0];
        quo_d   = {dvd_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dz_q        <= 1'b0;
            dvd_q       <= '0;
            rem_q       <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        dvd_q      <= a;
                        b_q        <= b;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        if (is_div) begin
                            state_q <= S_DIV;
                        end else begin
                            res_lo_q    <= lo_d;
                            res_hi_q    <= hi_d;
                            carry_q     <= carry_d;
                            zero_q      <= zero_d;
                            dz_q        <= dz_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    dvd_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        res_lo_q    <= quo_d;
                        res_hi_q    <= rem_d;
                        carry_q     <= 1'b0;
                        zero_q      <= ({rem_d, quo_d} == '0);
                        dz_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model results, a monitor
// compares them against every cycle the DUT presents out_valid.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res_lo;
    logic [W-1:0] res_hi;
    logic         carry;
    logic         zero;
    logic         dz;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res_lo   (res_lo),
        .res_hi   (res_hi),
        .carry    (carry),
        .zero     (zero),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         d;
        int           lat;
        int           acc;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rdy_mode = 1;
    int   next_id = 0;
    int   lat_id = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Sole driver of out_ready: 0 = hold off, 1 = always ready, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o);
        exp_t        e;
        int unsigned ua, ub, r, m;
        ua = x; ub = y; m = 1 << W;
        e.lo = '0; e.hi = '0; e.c = 1'b0; e.d = 1'b0; e.lat = 1; e.acc = 0; e.id = 0;
        case (o)
            4'd1: begin r = (ua + m - ub) % m; e.lo = W'(r); e.c = (ua < ub); end
            4'd2: begin r = ua * ub; e.lo = W'(r % m); e.hi = W'(r / m); end
            4'd3: begin
                if (ub == 0) begin
                    e.lo = W'(m - 1); e.hi = x; e.d = 1'b1;
                end else begin
                    e.lo = W'(ua / ub); e.hi = W'(ua % ub); e.lat = W + 1;
                end
            end
            4'd4:  begin e.lo = W'((ua * 2) % m); e.c = (ua >= m / 2); end
            4'd5:  begin e.lo = W'(ua / 2); e.c = ((ua % 2) == 1); end
            4'd8:  e.lo = x & y;
            4'd9:  e.lo = x | y;
            4'd10: e.lo = x ^ y;
            4'd11: e.lo = ~(x | y);
            4'd12: e.lo = ~(x & y);
            4'd13: e.lo = ~(x ^ y);
            default: begin r = ua + ub; e.lo = W'(r % m); e.c = (r >= m); end
        endcase
        e.z = (e.lo == 0) && (e.hi == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid: got out_valid=1 required no pending result (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb[0];
                if (e.id != lat_id) begin
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    lat_id = e.id;
                end
                chk("result{hi,lo,c,z,dz}", 64'({res_hi, res_lo, carry, zero, dz}),
                    64'({e.hi, e.lo, e.c, e.z, e.d}));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(posedge clk); #1;
        a = x; b = y; op = o; in_valid = 1'b1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 60 cycles required accept (op=%h)", o);
            in_valid = 1'b0;
        end else begin
            e = model(x, y, o);
            e.acc = cyc;
            e.id = next_id;
            next_id++;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        rdy_mode = 1;
        for (int n = 0; n < 300 && !empty; n++) begin
            @(negedge clk);
            if (sb.size() == 0) empty = 1'b1;
        end
        if (!empty) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] x, y;
        logic [3:0]   o;

        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({in_ready, out_valid, res_hi, res_lo, carry, zero, dz}), 64'(21'h100000));
        rst_n = 1'b1;

        issue(8'hFF, 8'h01, 4'b0000);
        issue(8'h05, 8'h07, 4'b0001);
        issue(8'hFF, 8'hFF, 4'b0010);
        issue(8'h81, 8'h00, 4'b0100);
        issue(8'h81, 8'h00, 4'b0101);
        issue(8'd200, 8'd7, 4'b0011);
        issue(8'h55, 8'h00, 4'b0011);
        issue(8'h00, 8'h09, 4'b0011);
        issue(8'h80, 8'h80, 4'b0111);
        issue(8'h5A, 8'hA5, 4'b1101);
        drain();

        // Backpressure: result must hold and a waiting op must not be taken.
        rdy_mode = 0;
        issue(8'hF0, 8'h3C, 4'b1100);
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22; op = 4'b0000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_res_lo", 64'(res_lo), 64'(8'hCF));
        end
        rdy_mode = 1;
        issue(8'h11, 8'h22, 4'b0000);
        drain();

        // Reset in the 4th divide cycle.
        issue(8'd200, 8'd7, 4'b0011);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_div", 64'({in_ready, out_valid, res_hi, res_lo, carry, zero, dz}), 64'(21'h100000));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd9, 8'd2, 4'b0011);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            x = W'($urandom);
            y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            o = 4'($urandom_range(0, 15));
            issue(x, y, o);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
